// File: rtl/seven_seg_result_scanner.sv
// Scans a 4-digit common-anode seven-segment display: digit 0 shows the latest
// prediction, digits 3..1 a BCD count of completed inferences.
module seven_seg_result_scanner #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned FLASH_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       count_clr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RefW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FlashW = $clog2(FLASH_CYCLES + 1);
  localparam logic [RefW-1:0]   RefMax    = RefW'(REFRESH_DIV - 1);
  localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_CYCLES);

  localparam logic [6:0] SegDash  = 7'h3F;
  localparam logic [6:0] SegE     = 7'h06;
  localparam logic [6:0] SegBlank = 7'h7F;

  logic [RefW-1:0]   r_ref;
  logic [1:0]        r_idx;
  logic [3:0]        r_units;
  logic [3:0]        r_tens;
  logic [3:0]        r_hund;
  logic [FlashW-1:0] r_flash;
  logic              r_have_digit;
  logic [3:0]        r_digit;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic [3:0] w_units_d;
  logic [3:0] w_tens_d;
  logic [3:0] w_hund_d;
  logic [3:0] w_an;
  logic [6:0] w_seg;
  logic       w_dp;

  // Values above 9 only reach this from the prediction slot and render as "E".
  function automatic logic [6:0] f_digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegE;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= '0;
      r_idx <= 2'd0;
    end else if (r_ref == RefMax) begin
      r_ref <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_ref <= r_ref + RefW'(1);
    end
  end

  // Ripple-carry BCD increment, 999 wraps to 000.
  always_comb begin
    w_units_d = r_units + 4'd1;
    w_tens_d  = r_tens;
    w_hund_d  = r_hund;
    if (r_units == 4'd9) begin
      w_units_d = 4'd0;
      w_tens_d  = r_tens + 4'd1;
      if (r_tens == 4'd9) begin
        w_tens_d = 4'd0;
        w_hund_d = (r_hund == 4'd9) ? 4'd0 : r_hund + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_units      <= 4'd0;
      r_tens       <= 4'd0;
      r_hund       <= 4'd0;
      r_flash      <= '0;
      r_have_digit <= 1'b0;
      r_digit      <= 4'd0;
    end else if (count_clr) begin
      r_units      <= 4'd0;
      r_tens       <= 4'd0;
      r_hund       <= 4'd0;
      r_flash      <= '0;
      r_have_digit <= 1'b0;
    end else if (digit_valid) begin
      r_units      <= w_units_d;
      r_tens       <= w_tens_d;
      r_hund       <= w_hund_d;
      r_flash      <= FlashLoad;
      r_have_digit <= 1'b1;
      r_digit      <= digit_in;
    end else if (r_flash != '0) begin
      r_flash <= r_flash - FlashW'(1);
    end
  end

  always_comb begin
    w_an = ~(4'b0001 << r_idx);
    w_dp = !((r_idx == 2'd0) && (r_flash != '0));
    unique case (r_idx)
      2'd0:    w_seg = r_have_digit ? f_digit_seg(r_digit) : SegDash;
      2'd1:    w_seg = f_digit_seg(r_units);
      2'd2:    w_seg = ((r_hund == 4'd0) && (r_tens == 4'd0)) ? SegBlank : f_digit_seg(r_tens);
      default: w_seg = (r_hund == 4'd0) ? SegBlank : f_digit_seg(r_hund);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= SegBlank;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seven_seg_result_scanner.sv
// Scoreboard bench for seven_seg_result_scanner with REFRESH_DIV=4, FLASH_CYCLES=10.
module tb_seven_seg_result_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       count_clr;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seven_seg_result_scanner #(
    .REFRESH_DIV (4),
    .FLASH_CYCLES(10)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .count_clr  (count_clr),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_item;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n      = 0;      // posedges since last reset release
  int   lastp  = -1000;  // edge that last loaded the flash counter

  // Monitor: outputs are registered, so every negedge presents a stable result.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      n_vec++;
      if (an !== mon_item.an || seg !== mon_item.seg || dp !== mon_item.dp) begin
        n_miss++;
        $display("FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 mon_item.name, an, seg, dp, mon_item.an, mon_item.seg, mon_item.dp);
      end
    end
  end

  task automatic push(input string name, input logic [3:0] a, input logic [6:0] s,
                      input logic d);
    exp_t e;
    e.name = name;
    e.an   = a;
    e.seg  = s;
    e.dp   = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Slot shown after edge k, given the slot changes every 4 edges starting at idx0.
  function automatic int slot(input int k);
    return ((k - 1) / 4) % 4;
  endfunction

  task automatic check_window(input string name, input int cycles, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3);
    int         idx;
    logic [6:0] s;
    logic       d;
    logic [3:0] a;
    for (int i = 0; i < cycles; i++) begin
      step();
      idx = slot(n);
      case (idx)
        0:       s = s0;
        1:       s = s1;
        2:       s = s2;
        default: s = s3;
      endcase
      a = 4'hF;
      a[idx] = 1'b0;
      d = !(idx == 0 && (n - 1) >= lastp && (n - 1) <= lastp + 9);
      push($sformatf("%s_n%0d_idx%0d", name, n, idx), a, s, d);
    end
  endtask

  task automatic pulse(input logic [3:0] d, input logic clr);
    digit_in    = d;
    digit_valid = 1'b1;
    count_clr   = clr;
    step();
    digit_valid = 1'b0;
    count_clr   = 1'b0;
    lastp       = clr ? -1000 : n;
  endtask

  task automatic clear();
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    lastp     = -1000;
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    push(name, 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    n     = 0;
    lastp = -1000;
  endtask

  initial begin
    int guard;
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    count_clr   = 1'b0;
    rst_n       = 1'b1;
    #2;
    do_reset("reset_state");

    // Idle scan: dash, units 0, blanks.
    check_window("idle", 32, 7'h3F, 7'h40, 7'h7F, 7'h7F);

    pulse(4'd7, 1'b0);
    check_window("digit7", 32, 7'h78, 7'h79, 7'h7F, 7'h7F);

    clear();
    for (int i = 0; i < 12; i++) pulse(4'd3, 1'b0);
    check_window("count12", 16, 7'h30, 7'h24, 7'h79, 7'h7F);

    clear();
    for (int i = 0; i < 999; i++) pulse(4'd9, 1'b0);
    check_window("count999", 16, 7'h10, 7'h10, 7'h10, 7'h10);
    pulse(4'd9, 1'b0);
    check_window("wrap000", 16, 7'h10, 7'h40, 7'h7F, 7'h7F);

    pulse(4'hC, 1'b0);
    check_window("digitE", 16, 7'h06, 7'h79, 7'h7F, 7'h7F);
    pulse(4'd5, 1'b1);
    check_window("clr_dom", 16, 7'h3F, 7'h40, 7'h7F, 7'h7F);

    // Land mid-slot on idx2, then reset asynchronously.
    guard = 0;
    while (!(slot(n) == 2 && ((n - 1) % 4) == 1) && guard < 20) begin
      step();
      guard++;
    end
    do_reset("async_reset_idx2");
    check_window("post_reset", 8, 7'h3F, 7'h40, 7'h7F, 7'h7F);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seven_seg_result_scanner.md
Name: seven_seg_result_scanner

Overview:
- Downstream consumer of the 4-bit predicted digit produced by the display reader stage.
- Drives a 4-digit common-anode, time-multiplexed seven-segment display:
  - digit 0 (rightmost) shows the latest prediction;
  - digits 3..1 show a BCD count (mod 1000) of completed inferences.
- Lights the decimal point on digit 0 briefly after each new prediction.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays selected (must be >= 2).
- FLASH_CYCLES, 25000000, cycles the digit-0 decimal point stays lit after a new prediction (must be >= 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- digit_in  input  4  predicted digit from display reader
- digit_valid  input  1  one-cycle pulse: new inference result present on digit_in
- count_clr  input  1  synchronous clear of inference count and displayed digit
- an  output  4  anode enables, active-low, an[0] = rightmost
- seg  output  7  segments active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is asynchronous and active-low. All outputs are registered.
- Reset values:
  - an=4'hF, seg=7'h7F, dp=1.
  - Scan index=0, refresh counter=0, BCD count=000, flash counter=0, have_digit=0, latched digit=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the scan index advances 0->1->2->3->0.
- Output timing:
  - an/seg/dp are computed from the current scan index and registered; they reflect a new index one cycle after it changes.
  - an = all ones except bit[idx]=0. Exactly one anode is low at any time after the first post-reset cycle.
- Digit latch:
  - On digit_valid: latched digit <= digit_in, have_digit <= 1, flash counter <= FLASH_CYCLES.
  - The latched value appears on the next digit-0 slot; no effect on the scan schedule.
- Inference count:
  - 3-digit BCD (hundreds, tens, units). Increments on each digit_valid.
  - Ripple carry per BCD digit; 999 wraps to 000.
- count_clr:
  - BCD count <= 000, have_digit <= 0, flash counter <= 0.
  - count_clr dominates a simultaneous digit_valid: count 000, have_digit 0, digit not latched.
- Flash counter:
  - Decrements by 1 per cycle while nonzero.
  - A new digit_valid reloads it to FLASH_CYCLES even if already nonzero.
- Per-slot content:
  - idx0: if have_digit=0, show dash; else latched digit 0-9, or "E" if latched value >9.
  - idx1: units BCD, always shown.
  - idx2: tens BCD; blank if hundreds=0 and tens=0.
  - idx3: hundreds BCD; blank if hundreds=0.
- dp: 0 only when idx=0 and flash counter != 0; otherwise 1.
- Segment codes, active-low, hex of {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - dash=3F, E=06, blank=7F
- Reset mid-scan: asserting rst_n=0 forces all outputs to reset values immediately, without waiting for a clock edge. Scanning restarts at idx0 after release.
- digit_valid arriving while any slot is displayed: the change is visible at that slot's next selection. No glitch within the currently displayed slot, except idx0 if it is the active slot, which updates on the next output register cycle.

Test Plan (REFRESH_DIV=4, FLASH_CYCLES=10):
- Reset then run 32 cycles, no valid:
  - an cycles E,D,B,7 with each value held 4 cycles;
  - seg=3F at idx0, 40 at idx1, 7F at idx2 and idx3; dp=1 throughout.
- digit_valid with digit_in=7:
  - idx0 seg=78 and idx1 seg=79;
  - dp=0 during idx0 slots for 10 cycles after the pulse, then 1.
- 12 digit_valid pulses, digit_in=3:
  - count 012: idx1 seg=24, idx2 seg=79, idx3 seg=7F;
  - idx0 seg=30.
- Preload 999 via pulses, one more digit_valid:
  - count 000: idx1 seg=40, idx2/idx3 seg=7F.
- digit_in=4'hC with digit_valid -> idx0 seg=06. Then count_clr and digit_valid in the same cycle -> idx0 seg=3F, count 000, dp=1.
- Assert rst_n=0 mid-slot at idx2 -> an=F, seg=7F, dp=1 before the next clk edge. After release, first selected anode is an=E.
